// File: rtl/aes_sbox_pipe_if.sv
// Valid/ready transaction bundle for aes_sbox_pipe: request side (valid_i/inv_i/data_i)
// and response side (valid_o/inv_o/data_o), with the matching ready signals.
interface aes_sbox_pipe_if #(parameter int LANES = 4);
  logic                   valid_i;
  logic                   ready_o;
  logic                   inv_i;
  logic [LANES-1:0][7:0]  data_i;
  logic                   valid_o;
  logic                   ready_i;
  logic                   inv_o;
  logic [LANES-1:0][7:0]  data_o;

  modport master (output valid_i, inv_i, data_i, ready_i,
                  input  ready_o, valid_o, inv_o, data_o);
  modport slave  (input  valid_i, inv_i, data_i, ready_i,
                  output ready_o, valid_o, inv_o, data_o);
endinterface

// File: rtl/aes_sbox_pipe.sv
// Multi-lane AES S-box using a shared GF((2^4)^2) inversion and a 2-stage valid/ready pipe.
// Define AES_SBOX_MODE_EN for forward+inverse; without it the datapath is inverse-only.

module aes_sbox_lane (
  input  logic [7:0] in_byte,
`ifdef AES_SBOX_MODE_EN
  input  logic       in_inv,
  input  logic       mid_inv,
`endif
  output logic [7:0] top_o,
  input  logic [7:0] mid_i,
  output logic [7:0] out_byte
);
  typedef logic [7:0][7:0] mat8_t;  // row r = mask of input bits XORed into output bit r

  // GF(2^4) with modulus x^4 + x + 1
  function automatic logic [3:0] g4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r ^= t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] g4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = g4_mul(a, a);
    a4 = g4_mul(a2, a2);
    a8 = g4_mul(a4, a4);
    return g4_mul(g4_mul(a2, a4), a8);  // a^14
  endfunction

  // Tower element {h,l} = h*y + l, with y^2 = y + lam
  function automatic logic [7:0] tw_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] lam);
    logic [3:0] hh;
    hh = g4_mul(a[7:4], b[7:4]);
    return {hh ^ g4_mul(a[7:4], b[3:0]) ^ g4_mul(a[3:0], b[7:4]),
            g4_mul(hh, lam) ^ g4_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [7:0] tw_inv(input logic [7:0] a, input logic [3:0] lam);
    logic [3:0] ah, al, d, di;
    ah = a[7:4];
    al = a[3:0];
    d  = g4_mul(g4_mul(ah, ah), lam) ^ g4_mul(ah, al) ^ g4_mul(al, al);
    di = g4_inv(d);
    return {g4_mul(ah, di), g4_mul(ah ^ al, di)};
  endfunction

  function automatic logic [7:0] mat_apply(input mat8_t m, input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = ^(m[i] & v);
    return r;
  endfunction

  function automatic mat8_t mat_mul(input mat8_t a, input mat8_t b);
    mat8_t      r;
    logic [7:0] col;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      col = mat_apply(a, mat_apply(b, 8'h01 << i));
      for (int k = 0; k < 8; k++) r[k][i] = col[k];
    end
    return r;
  endfunction

  function automatic mat8_t mat_inv(input mat8_t a);
    mat8_t      r;
    logic [7:0] col;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      col = '0;
      for (int e = 0; e < 256; e++)
        if (mat_apply(a, 8'(e)) == (8'h01 << j)) col = 8'(e);
      for (int k = 0; k < 8; k++) r[k][j] = col[k];
    end
    return r;
  endfunction

  // Any lam with y^2+y+lam irreducible over GF(2^4) gives a valid tower
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic       hit;
    lam = 4'h0;
    for (int c = 15; c >= 1; c--) begin
      hit = 1'b0;
      for (int t = 0; t < 16; t++)
        if ((g4_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(c)) hit = 1'b1;
      if (!hit) lam = 4'(c);
    end
    return lam;
  endfunction

  // Map the AES generator to a tower root of x^8+x^4+x^3+x+1; column i is root^i
  function automatic mat8_t find_iso(input logic [3:0] lam);
    mat8_t           m;
    logic [8:0][7:0] p;
    logic [7:0]      root;
    root = '0;
    for (int c = 255; c >= 2; c--) begin
      p[0] = 8'h01;
      for (int i = 1; i < 9; i++) p[i] = tw_mul(p[i-1], 8'(c), lam);
      if ((p[8] ^ p[4] ^ p[3] ^ p[1] ^ p[0]) == 8'h00) root = 8'(c);
    end
    p[0] = 8'h01;
    for (int i = 1; i < 9; i++) p[i] = tw_mul(p[i-1], root, lam);
    m = '0;
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 8; i++) m[r][i] = p[i][r];
    return m;
  endfunction

  function automatic mat8_t aff_mat();
    mat8_t      m;
    logic [7:0] row;
    row = 8'hF1;
    for (int i = 0; i < 8; i++) begin
      m[i] = row;
      row  = {row[6:0], row[7]};
    end
    return m;
  endfunction

  localparam logic [3:0] LAM       = find_lambda();
  localparam mat8_t      ISO       = find_iso(LAM);
  localparam mat8_t      ISO_INV   = mat_inv(ISO);
  localparam mat8_t      AFF       = aff_mat();
  localparam mat8_t      AFF_INV   = mat_inv(AFF);
  localparam mat8_t      INV_TOP   = mat_mul(ISO, AFF_INV);
  localparam logic [7:0] INV_TOP_C = mat_apply(INV_TOP, 8'h63);

  logic [7:0] mid_inv_v;
  assign mid_inv_v = tw_inv(mid_i, LAM);

`ifdef AES_SBOX_MODE_EN
  localparam mat8_t FWD_BOT = mat_mul(AFF, ISO_INV);
  assign top_o    = in_inv  ? (mat_apply(INV_TOP, in_byte) ^ INV_TOP_C) : mat_apply(ISO, in_byte);
  assign out_byte = mid_inv ? mat_apply(ISO_INV, mid_inv_v) : (mat_apply(FWD_BOT, mid_inv_v) ^ 8'h63);
`else
  assign top_o    = mat_apply(INV_TOP, in_byte) ^ INV_TOP_C;
  assign out_byte = mat_apply(ISO_INV, mid_inv_v);
`endif
endmodule

module aes_sbox_pipe #(
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           nreset,
  aes_sbox_pipe_if.slave bus
);
  logic [2:1]            vld_pipe;
  logic                  s1_inv, s2_inv, in_mode;
  logic                  ready, acc, adv;
  logic [LANES-1:0][7:0] d_in, top_w, s1_q, bot_w, s2_q;

  // ready_i feeds ready combinationally so a full pipe can stream
  assign ready = !vld_pipe[1] | !vld_pipe[2] | bus.ready_i;
  assign acc   = bus.valid_i & ready;
  assign adv   = vld_pipe[1] & (!vld_pipe[2] | bus.ready_i);
  assign d_in  = bus.data_i;

`ifdef AES_SBOX_MODE_EN
  assign in_mode = bus.inv_i;
  aes_sbox_lane u_lane [LANES-1:0] (
    .in_byte (d_in),
    .in_inv  (bus.inv_i),
    .mid_inv (s1_inv),
    .top_o   (top_w),
    .mid_i   (s1_q),
    .out_byte(bot_w)
  );
`else
  logic unused_inv;
  assign unused_inv = bus.inv_i;
  assign in_mode    = 1'b1;
  aes_sbox_lane u_lane [LANES-1:0] (
    .in_byte (d_in),
    .top_o   (top_w),
    .mid_i   (s1_q),
    .out_byte(bot_w)
  );
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_pipe <= '0;
      s1_inv   <= 1'b0;
      s2_inv   <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (acc) begin
        vld_pipe[1] <= 1'b1;
        s1_q        <= top_w;
        s1_inv      <= in_mode;
      end else if (adv) begin
        vld_pipe[1] <= 1'b0;
      end
      if (adv) begin
        vld_pipe[2] <= 1'b1;
        s2_q        <= bot_w;
        s2_inv      <= s1_inv;
      end else if (bus.ready_i) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  assign bus.ready_o = ready;
  assign bus.valid_o = vld_pipe[2];
  assign bus.inv_o   = s2_inv;
  assign bus.data_o  = s2_q;
endmodule

// File: doc/aes_sbox_pipe.md
AES_SBOX_PIPE -- requirements
Module: aes_sbox_pipe

Interface
REQ-001 Parameter LANES, default 4: number of byte lanes processed per transaction (1..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 nreset  input  1  reset, asynchronous assert, active-low.
REQ-004 valid_i  input  1  input transaction present.
REQ-005 ready_o  output  1  block accepts the input transaction this cycle.
REQ-006 inv_i  input  1  mode of the transaction: 1 = inverse S-box, 0 = forward S-box.
REQ-007 data_i  input  8*LANES  input bytes; lane k = data_i[8k+7:8k], bit 7 = MSB.
REQ-008 valid_o  output  1  output transaction present.
REQ-009 ready_i  input  1  downstream accepts the output transaction this cycle.
REQ-010 inv_o  output  1  mode the output transaction was computed with.
REQ-011 data_o  output  8*LANES  substituted bytes, same lane mapping as data_i.

Function
REQ-012 Each lane shall compute the AES S-box (FIPS-197) of its byte, or the inverse S-box when the transaction's mode is 1; lanes are independent.
REQ-013 The datapath shall be a shared-inversion Boolean circuit: top linear layer, GF(2^4)-based inversion, bottom linear layer, with mode-selected top and bottom layers; no lookup tables.
REQ-014 Two pipeline stages: S1 registers the top-layer outputs, mode, and valid; S2 registers the final bytes, mode, and valid, and drives data_o/inv_o/valid_o.
REQ-015 Latency: 2 cycles from the accept edge (valid_i & ready_o) to valid_o, when no backpressure occurs.
REQ-016 Throughput: one transaction per cycle when ready_i is held high.
REQ-017 ready_o = !S1.valid | !S2.valid | ready_i; this combinational path from ready_i is intended.
REQ-018 S2 loads from S1 when S1.valid & (!S2.valid | ready_i); S2.valid clears when ready_i & !S1.valid.
REQ-019 S1 loads from the inputs when valid_i & ready_o; S1.valid clears when S1 advances and no new input is accepted.
REQ-020 While valid_o & !ready_i, data_o, inv_o and valid_o shall hold stable.
REQ-021 Full pipe (S1 and S2 valid) with ready_i=0: ready_o=0, no state change.
REQ-022 Simultaneous output consume and input accept on a full pipe: S1 moves to S2 and the new input enters S1 in the same edge, with no bubble and no loss.
REQ-023 Mode is tracked per transaction; back-to-back transactions with different modes shall not interfere.
REQ-024 Transactions shall exit in acceptance order, with no duplication or drop.

Reset
REQ-025 While nreset=0: S1.valid=0, S2.valid=0, valid_o=0, inv_o=0, data_o=0, and ready_o=1 once the valids are cleared.
REQ-026 Reset asserted mid-operation discards all in-flight transactions immediately (asynchronous).
REQ-027 First accept is possible on the first rising clk edge after nreset deasserts.

Configuration
REQ-028 Macro AES_SBOX_MODE_EN defined: forward and inverse modes are both implemented per REQ-006/012.
REQ-029 Macro AES_SBOX_MODE_EN undefined: inverse-only datapath; inv_i is ignored, inv_o=1 whenever valid_o=1 (0 in reset), and no forward-layer logic is synthesised.

Verification
REQ-030 LANES=4, forward mode, data_i=0x53_00_01_FF, valid_i one cycle, ready_i=1 -> 2 cycles later valid_o=1, data_o=0xED_63_7C_16, inv_o=0.
REQ-031 Inverse mode, data_i=0xED_63_00_16 -> data_o=0x53_00_52_FF after 2 cycles, inv_o=1.
REQ-032 Stream of 256 transactions covering bytes 0x00..0xFF, alternating modes each cycle, ready_i=1 -> every result matches the FIPS-197 table, one result per cycle, in order.
REQ-033 Two transactions accepted, then ready_i=0 for 5 cycles -> ready_o=0 after the pipe fills, data_o stable; then ready_i=1 -> both transactions exit in order on consecutive cycles.
REQ-034 Random valid_i/ready_i (50%) for 10k transactions -> scoreboard shows no loss, duplication or reordering.
REQ-035 nreset pulsed low with S1 and S2 valid -> valid_o=0 and data_o=0 asynchronously; no stale output after release.
